// File: rtl/regs_file_scoreboard.sv
// Register file with NUM_RD read ports, NUM_FWD-source forwarding and a per-register pending-write scoreboard.
// Define REGS_SB_STATS_EN to add the Stall_Cnt_o_Regs stall-cycle counter output.
module regs_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_FWD  = 2,
  parameter int MAX_PEND = 3
) (
  input  logic                      clk_i_Regs,
  input  logic                      rst_i_Regs,
  input  logic [NUM_RD-1:0]         RdEn_i_Regs,
  input  logic [NUM_RD*ADDR_W-1:0]  Rd_Addr_i_Regs,
  output logic [NUM_RD*DATA_W-1:0]  Rd_Data_o_Regs,
  output logic [NUM_RD*ADDR_W-1:0]  Rd_Addr_o_Regs,
  input  logic                      Iss_En_i_Regs,
  input  logic [ADDR_W-1:0]         Iss_Addr_i_Regs,
  input  logic [NUM_FWD-1:0]        Fwd_Valid_i_Regs,
  input  logic [NUM_FWD*ADDR_W-1:0] Fwd_Addr_i_Regs,
  input  logic [NUM_FWD*DATA_W-1:0] Fwd_Data_i_Regs,
  input  logic                      WrEn_i_Regs,
  input  logic [ADDR_W-1:0]         WrAddr_i_Regs,
  input  logic [DATA_W-1:0]         WrData_i_Regs,
  input  logic                      Flush_i_Regs,
  output logic                      Stall_o_Regs,
`ifdef REGS_SB_STATS_EN
  output logic [31:0]               Stall_Cnt_o_Regs,
`endif
  output logic                      Ovf_Err_o_Regs,
  output logic                      Udf_Err_o_Regs
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              inc, dec;

  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_data [NUM_RD];
  logic              fwd_hit [NUM_RD];
  logic              wb_hit  [NUM_RD];

  assign Rd_Addr_o_Regs = Rd_Addr_i_Regs;
  assign Ovf_Err_o_Regs = ovf_q;
  assign Udf_Err_o_Regs = udf_q;
  assign inc = Iss_En_i_Regs && (Iss_Addr_i_Regs != '0);
  assign dec = WrEn_i_Regs && (WrAddr_i_Regs != '0);

  // Read path: forwarding (youngest first) beats same-cycle writeback beats the array
  always_comb begin
    Rd_Data_o_Regs = '0;
    Stall_o_Regs   = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = Rd_Addr_i_Regs[k*ADDR_W +: ADDR_W];
      wb_hit[k]  = WrEn_i_Regs && (WrAddr_i_Regs == rd_addr[k]);
      rd_data[k] = wb_hit[k] ? WrData_i_Regs : regs_q[rd_addr[k]];
      fwd_hit[k] = 1'b0;
      for (int f = NUM_FWD - 1; f >= 0; f--) begin
        if (Fwd_Valid_i_Regs[f] && (Fwd_Addr_i_Regs[f*ADDR_W +: ADDR_W] == rd_addr[k])) begin
          rd_data[k] = Fwd_Data_i_Regs[f*DATA_W +: DATA_W];
          fwd_hit[k] = 1'b1;
        end
      end
      if (RdEn_i_Regs[k] && (rd_addr[k] != '0)) begin
        Rd_Data_o_Regs[k*DATA_W +: DATA_W] = rd_data[k];
        if ((cnt_q[rd_addr[k]] != '0) && !fwd_hit[k] && !wb_hit[k])
          Stall_o_Regs = 1'b1;
      end
    end
  end

  // Array write and pending-count update; flush clears counts but not the WB data write
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (dec)
      regs_d[WrAddr_i_Regs] = WrData_i_Regs;
    if (!(inc && dec && (Iss_Addr_i_Regs == WrAddr_i_Regs))) begin
      if (inc) begin
        if (cnt_q[Iss_Addr_i_Regs] == CNT_MAX) ovf_d = 1'b1;
        else cnt_d[Iss_Addr_i_Regs] = cnt_q[Iss_Addr_i_Regs] + CNT_ONE;
      end
      if (dec) begin
        if (cnt_q[WrAddr_i_Regs] == '0) udf_d = 1'b1;
        else cnt_d[WrAddr_i_Regs] = cnt_q[WrAddr_i_Regs] - CNT_ONE;
      end
    end
    if (Flush_i_Regs) begin
      for (int i = 0; i < NREG; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i_Regs) begin
    if (rst_i_Regs) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

`ifdef REGS_SB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d      = stall_cnt_q + {31'd0, Stall_o_Regs};
  assign Stall_Cnt_o_Regs = stall_cnt_q;

  always_ff @(posedge clk_i_Regs) begin
    if (rst_i_Regs) stall_cnt_q <= '0;
    else            stall_cnt_q <= stall_cnt_d;
  end
`endif

endmodule

// File: tb/tb_regs_file_scoreboard.sv
// Scoreboard-driven bench for regs_file_scoreboard: expected read data/stall queued at drive time, popped on the falling edge.
module tb_regs_file_scoreboard;
  localparam int DW = 32, AW = 5, NR = 2, NF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr, rd_addr_o;
  logic [NR*DW-1:0] rd_data;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic [NF-1:0]    fwd_valid;
  logic [NF*AW-1:0] fwd_addr;
  logic [NF*DW-1:0] fwd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             flush, stall, ovf, udf;
`ifdef REGS_SB_STATS_EN
  logic [31:0]      stall_cnt;
`endif

  regs_file_scoreboard dut (
    .clk_i_Regs(clk), .rst_i_Regs(rst),
    .RdEn_i_Regs(rd_en), .Rd_Addr_i_Regs(rd_addr),
    .Rd_Data_o_Regs(rd_data), .Rd_Addr_o_Regs(rd_addr_o),
    .Iss_En_i_Regs(iss_en), .Iss_Addr_i_Regs(iss_addr),
    .Fwd_Valid_i_Regs(fwd_valid), .Fwd_Addr_i_Regs(fwd_addr), .Fwd_Data_i_Regs(fwd_data),
    .WrEn_i_Regs(wr_en), .WrAddr_i_Regs(wr_addr), .WrData_i_Regs(wr_data),
    .Flush_i_Regs(flush), .Stall_o_Regs(stall),
`ifdef REGS_SB_STATS_EN
    .Stall_Cnt_o_Regs(stall_cnt),
`endif
    .Ovf_Err_o_Regs(ovf), .Udf_Err_o_Regs(udf)
  );

  typedef struct packed {
    logic             stall;
    logic [NR*DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   tests = 0, fails = 0, exp_stalls = 0;

  task automatic idle();
    rd_en = '0; rd_addr = '0; iss_en = 1'b0; iss_addr = '0;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; flush = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
    rd_en = en; rd_addr = {a1, a0};
  endtask

  task automatic push(input logic [DW-1:0] d1, input logic [DW-1:0] d0, input logic st);
    sb_q.push_back({st, d1, d0});
    if (st) exp_stalls++;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    exp_stalls = 0;
    for (int a = 0; a < 32; a++) begin
      rd(AW'(a), AW'(31 - a), 2'b11); push(32'h0, 32'h0, 1'b0);
      @(negedge clk); e = sb_q.pop_front(); tests++;
      if ({stall, rd_data} !== e) begin fails++;
        $display("FAIL reset_read x%0d: got stall=%0b data=%h, want stall=%0b data=%h", a, stall, rd_data, e.stall, e.data); end
      cyc();
    end
    tests++;
    if ({ovf, udf} !== 2'b00) begin fails++; $display("FAIL reset_errs: got %b, want 00", {ovf, udf}); end
`ifdef REGS_SB_STATS_EN
    tests++;
    if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d, want 0", stall_cnt); end
`endif
  endtask

  task automatic test_bypass();
    idle(); iss_en = 1'b1; iss_addr = 5; cyc();
    idle(); wr_en = 1'b1; wr_addr = 5; wr_data = 32'h12345678; rd(5, 0, 2'b01);
    push(32'h0, 32'h12345678, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL bypass_wb: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); rd(5, 5, 2'b11); push(32'h12345678, 32'h12345678, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL array_after_wb: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    tests++;
    if (rd_addr_o !== {5'd5, 5'd5}) begin fails++; $display("FAIL addr_echo: got %h, want %h", rd_addr_o, {5'd5, 5'd5}); end
    cyc();
    idle(); rd(5, 5, 2'b01); push(32'h0, 32'h12345678, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL port_disabled: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    tests++;
    if (udf !== 1'b0) begin fails++; $display("FAIL bypass_no_udf: got %b, want 0", udf); end
    cyc();
  endtask

  task automatic test_fwd();
    idle(); iss_en = 1'b1; iss_addr = 7; cyc();
    idle(); rd(7, 7, 2'b01); push(32'h0, 32'h0, 1'b1);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL stall_no_fwd: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); rd(7, 7, 2'b11); fwd_valid = 2'b10; fwd_addr = {5'd7, 5'd0}; fwd_data = {32'hA5, 32'h0};
    push(32'hA5, 32'hA5, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL fwd_src1: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); rd(7, 7, 2'b11); fwd_valid = 2'b11; fwd_addr = {5'd7, 5'd7}; fwd_data = {32'h22, 32'h11};
    push(32'h11, 32'h11, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL fwd_priority: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); rd(7, 7, 2'b01); fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd8}; fwd_data = {32'h0, 32'h88};
    push(32'h0, 32'h0, 1'b1);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL fwd_other_addr: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); rd(7, 7, 2'b11); fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd7}; fwd_data = {32'h0, 32'h33};
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h77; push(32'h33, 32'h33, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL fwd_over_wb: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); rd(7, 7, 2'b11); push(32'h77, 32'h77, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL x7_retired: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
  endtask

  task automatic test_x0();
    idle(); iss_en = 1'b1; iss_addr = 0; wr_en = 1'b1; wr_addr = 0; wr_data = 32'hDEADBEEF;
    fwd_valid = 2'b01; fwd_addr = '0; fwd_data = {32'h0, 32'hBAD}; rd(0, 0, 2'b11);
    push(32'h0, 32'h0, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL x0_read: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); rd(0, 0, 2'b11); push(32'h0, 32'h0, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL x0_after: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    tests++;
    if ({ovf, udf} !== 2'b00) begin fails++; $display("FAIL x0_no_err: got %b, want 00", {ovf, udf}); end
    cyc();
  endtask

  task automatic test_ovf();
    for (int i = 0; i < 4; i++) begin
      idle(); iss_en = 1'b1; iss_addr = 3; cyc();
      tests++;
      if (ovf !== (i == 3)) begin fails++; $display("FAIL ovf_issue%0d: got %b, want %b", i, ovf, (i == 3)); end
    end
    idle(); rd(3, 0, 2'b01); push(32'h0, 32'h0, 1'b1);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL ovf_stall: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); wr_en = 1'b1; wr_addr = 3; wr_data = DW'(i + 1); cyc();
      idle(); rd(3, 0, 2'b01); push(32'h0, DW'(i + 1), (i < 2));
      @(negedge clk); e = sb_q.pop_front(); tests++;
      if ({stall, rd_data} !== e) begin fails++;
        $display("FAIL retire_x3_%0d: got stall=%0b data=%h, want stall=%0b data=%h", i, stall, rd_data, e.stall, e.data); end
      cyc();
    end
    tests++;
    if (udf !== 1'b0) begin fails++; $display("FAIL ovf_no_udf: got %b, want 0", udf); end
  endtask

  task automatic test_udf();
    idle(); wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99; cyc();
    idle(); rd(9, 0, 2'b01); push(32'h0, 32'h99, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL udf_write: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    tests++;
    if (udf !== 1'b1) begin fails++; $display("FAIL udf_flag: got %b, want 1", udf); end
    cyc();
    idle(); iss_en = 1'b1; iss_addr = 9; cyc();
    idle(); iss_en = 1'b1; iss_addr = 9; wr_en = 1'b1; wr_addr = 9; wr_data = 32'h9A; cyc();
    idle(); rd(9, 9, 2'b11); push(32'h9A, 32'h9A, 1'b1);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL iss_wb_same: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); wr_en = 1'b1; wr_addr = 9; wr_data = 32'h9B; cyc();
    idle(); rd(9, 0, 2'b01); push(32'h0, 32'h9B, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL udf_retire: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    tests++;
    if (udf !== 1'b1) begin fails++; $display("FAIL udf_sticky: got %b, want 1", udf); end
    cyc();
  endtask

  task automatic test_flush();
    idle(); iss_en = 1'b1; iss_addr = 4; cyc();
    idle(); iss_en = 1'b1; iss_addr = 6; cyc();
    idle(); rd(4, 6, 2'b11); push(32'h0, 32'h0, 1'b1);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL pre_flush: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); flush = 1'b1; wr_en = 1'b1; wr_addr = 4; wr_data = 32'h55; cyc();
    idle(); rd(4, 6, 2'b11); push(32'h0, 32'h55, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL post_flush: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
    idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 10; cyc();
    idle(); rd(10, 0, 2'b01); push(32'h0, 32'h0, 1'b0);
    @(negedge clk); e = sb_q.pop_front(); tests++;
    if ({stall, rd_data} !== e) begin fails++;
      $display("FAIL flush_over_iss: got stall=%0b data=%h, want stall=%0b data=%h", stall, rd_data, e.stall, e.data); end
    cyc();
`ifdef REGS_SB_STATS_EN
    tests++;
    if (stall_cnt !== 32'(exp_stalls)) begin fails++;
      $display("FAIL stall_cnt: got %0d, want %0d", stall_cnt, exp_stalls); end
`endif
  endtask

  initial begin
    idle(); rst = 1'b1;
    test_reset();
    test_bypass();
    test_fwd();
    test_x0();
    test_ovf();
    test_udf();
    test_flush();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
